// File: rtl/auto_drive_ctrl.sv
// RC-car drive controller: manual/autonomous target selection plus per-motor duty ramp
// with brake-before-reverse. Optional sensor watchdog enabled by defining DIST_WDOG_EN.
module auto_drive_ctrl #(
    parameter int unsigned DIST_W      = 16,
    parameter int unsigned DUTY_W      = 7,
    parameter int unsigned FRONT_STOP  = 32,
    parameter int unsigned FRONT_SLOW  = 60,
    parameter int unsigned SIDE_NEAR   = 25,
    parameter int unsigned CRUISE_DUTY = 40,
    parameter int unsigned TURN_DUTY   = 40,
    parameter int unsigned MAN_DUTY    = 80,
    parameter int unsigned RAMP_STEP   = 5,
    parameter int unsigned RAMP_DIV    = 100000,
    parameter int unsigned WDOG_CYC    = 5000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_go,
    input  logic              btn_right,
    input  logic              btn_left,
    input  logic              btn_auto,
    input  logic              btn_stop,
    input  logic [DIST_W-1:0] dist_front,
    input  logic [DIST_W-1:0] dist_right,
    input  logic [DIST_W-1:0] dist_left,
    input  logic              dist_valid,
    output logic              in1,
    output logic              in2,
    output logic              in3,
    output logic              in4,
    output logic [DUTY_W-1:0] right_duty,
    output logic [DUTY_W-1:0] left_duty,
    output logic [1:0]        mode,
    output logic [2:0]        state
);
    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_MANUAL = 2'd1;
    localparam logic [1:0] MODE_AUTO   = 2'd2;

    localparam logic [2:0] ST_HOLD   = 3'd0;
    localparam logic [2:0] ST_CRUISE = 3'd1;
    localparam logic [2:0] ST_SLOW   = 3'd2;
    localparam logic [2:0] ST_VEER_L = 3'd3;
    localparam logic [2:0] ST_VEER_R = 3'd4;
    localparam logic [2:0] ST_SPIN_L = 3'd5;
    localparam logic [2:0] ST_SPIN_R = 3'd6;
    localparam logic [2:0] ST_FAULT  = 3'd7;

    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;

    // Targets are clamped to the pwm_100 range once, at elaboration.
    localparam int unsigned MAN_C      = (MAN_DUTY > 100) ? 100 : MAN_DUTY;
    localparam int unsigned CRUISE_C   = (CRUISE_DUTY > 100) ? 100 : CRUISE_DUTY;
    localparam int unsigned CRUISE_H_C = (CRUISE_DUTY / 2 > 100) ? 100 : CRUISE_DUTY / 2;
    localparam int unsigned TURN_C     = (TURN_DUTY > 100) ? 100 : TURN_DUTY;
    localparam int unsigned TURN_H_C   = (TURN_DUTY / 2 > 100) ? 100 : TURN_DUTY / 2;

    localparam logic [DUTY_W-1:0] D_MAN      = DUTY_W'(MAN_C);
    localparam logic [DUTY_W-1:0] D_CRUISE   = DUTY_W'(CRUISE_C);
    localparam logic [DUTY_W-1:0] D_CRUISE_H = DUTY_W'(CRUISE_H_C);
    localparam logic [DUTY_W-1:0] D_TURN     = DUTY_W'(TURN_C);
    localparam logic [DUTY_W-1:0] D_TURN_H   = DUTY_W'(TURN_H_C);
    localparam logic [DUTY_W-1:0] D_STEP     = DUTY_W'(RAMP_STEP);

    localparam logic [DIST_W-1:0] L_FRONT_STOP = DIST_W'(FRONT_STOP);
    localparam logic [DIST_W-1:0] L_FRONT_SLOW = DIST_W'(FRONT_SLOW);
    localparam logic [DIST_W-1:0] L_SIDE_NEAR  = DIST_W'(SIDE_NEAR);

    localparam int unsigned TICK_W = $clog2(RAMP_DIV);

    logic [1:0]        r_mode;
    logic [2:0]        r_state;
    logic [1:0]        r_tdir_r, r_tdir_l;
    logic [1:0]        r_dir_r, r_dir_l;
    logic [DUTY_W-1:0] r_tgt_r, r_tgt_l;
    logic [DUTY_W-1:0] r_duty_r, r_duty_l;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic              w_wdog_hit;
    logic [2:0]        w_auto_state;
    logic [1:0]        w_auto_dir_r, w_auto_dir_l;
    logic [DUTY_W-1:0] w_auto_r, w_auto_l;
    logic [DUTY_W+1:0] w_next_r, w_next_l;

    always_comb begin
        w_auto_state = ST_CRUISE;
        w_auto_dir_r = DIR_FWD;
        w_auto_dir_l = DIR_FWD;
        w_auto_r     = D_CRUISE;
        w_auto_l     = D_CRUISE;
        if (dist_front < L_FRONT_STOP) begin
            if (dist_right > dist_left) begin
                w_auto_state = ST_SPIN_R;
                w_auto_dir_r = DIR_REV;
                w_auto_r     = D_TURN_H;
                w_auto_l     = D_TURN;
            end else begin
                w_auto_state = ST_SPIN_L;
                w_auto_dir_l = DIR_REV;
                w_auto_r     = D_TURN;
                w_auto_l     = D_TURN_H;
            end
        end else if (dist_right < L_SIDE_NEAR || dist_left < L_SIDE_NEAR) begin
            if (dist_right > dist_left) begin
                w_auto_state = ST_VEER_R;
                w_auto_r     = '0;
            end else begin
                w_auto_state = ST_VEER_L;
                w_auto_l     = '0;
            end
        end else if (dist_front < L_FRONT_SLOW) begin
            w_auto_state = ST_SLOW;
            w_auto_r     = D_CRUISE_H;
            w_auto_l     = D_CRUISE_H;
        end
    end

`ifdef DIST_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] r_wdog_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_wdog_cnt <= '0;
        else if (btn_stop || btn_auto || btn_go || btn_right || btn_left ||
                 r_mode != MODE_AUTO || dist_valid)
            r_wdog_cnt <= '0;
        else if (r_state != ST_FAULT)
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end

    assign w_wdog_hit = (r_mode == MODE_AUTO) && (r_state != ST_FAULT) && !dist_valid &&
                        (r_wdog_cnt == WDOG_W'(WDOG_CYC - 1));
`else
    assign w_wdog_hit = 1'b0;
`endif

    // Buttons override everything; stop/hold/fault zero the targets but keep target dirs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode   <= MODE_IDLE;
            r_state  <= ST_HOLD;
            r_tdir_r <= 2'b00;
            r_tdir_l <= 2'b00;
            r_tgt_r  <= '0;
            r_tgt_l  <= '0;
        end else if (btn_stop) begin
            r_mode  <= MODE_IDLE;
            r_state <= ST_HOLD;
            r_tgt_r <= '0;
            r_tgt_l <= '0;
        end else if (btn_auto) begin
            r_mode  <= MODE_AUTO;
            r_state <= ST_HOLD;
            r_tgt_r <= '0;
            r_tgt_l <= '0;
        end else if (btn_go || btn_right || btn_left) begin
            r_mode   <= MODE_MANUAL;
            r_state  <= ST_HOLD;
            r_tdir_r <= DIR_FWD;
            r_tdir_l <= DIR_FWD;
            r_tgt_r  <= (btn_go || !btn_right) ? D_MAN : '0;
            r_tgt_l  <= (btn_go || btn_right) ? D_MAN : '0;
        end else if (dist_valid && r_mode == MODE_AUTO && r_state != ST_FAULT) begin
            r_state  <= w_auto_state;
            r_tdir_r <= w_auto_dir_r;
            r_tdir_l <= w_auto_dir_l;
            r_tgt_r  <= w_auto_r;
            r_tgt_l  <= w_auto_l;
        end else if (w_wdog_hit) begin
            r_state <= ST_FAULT;
            r_tgt_r <= '0;
            r_tgt_l <= '0;
        end
    end

    assign w_tick = (r_tick_cnt == TICK_W'(RAMP_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // Returns {dir, duty}. Direction flips only at zero duty; an idle motor keeps its dir.
    function automatic logic [DUTY_W+1:0] ramp_next(input logic [1:0]        dir,
                                                    input logic [DUTY_W-1:0] duty,
                                                    input logic [1:0]        tdir,
                                                    input logic [DUTY_W-1:0] tduty);
        logic [1:0]        n_dir;
        logic [DUTY_W-1:0] n_duty;
        n_dir  = dir;
        n_duty = duty;
        if (tdir != dir) begin
            if (duty == '0) begin
                if (tduty != '0)
                    n_dir = tdir;
            end else begin
                n_duty = (duty > D_STEP) ? duty - D_STEP : '0;
            end
        end else if (duty < tduty) begin
            n_duty = (tduty - duty > D_STEP) ? duty + D_STEP : tduty;
        end else if (duty > tduty) begin
            n_duty = (duty - tduty > D_STEP) ? duty - D_STEP : tduty;
        end
        return {n_dir, n_duty};
    endfunction

    assign w_next_r = ramp_next(r_dir_r, r_duty_r, r_tdir_r, r_tgt_r);
    assign w_next_l = ramp_next(r_dir_l, r_duty_l, r_tdir_l, r_tgt_l);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir_r  <= 2'b00;
            r_dir_l  <= 2'b00;
            r_duty_r <= '0;
            r_duty_l <= '0;
        end else if (w_tick) begin
            {r_dir_r, r_duty_r} <= w_next_r;
            {r_dir_l, r_duty_l} <= w_next_l;
        end
    end

    assign {in1, in2}  = r_dir_r;
    assign {in3, in4}  = r_dir_l;
    assign right_duty  = r_duty_r;
    assign left_duty   = r_duty_l;
    assign mode        = r_mode;
    assign state       = r_state;
endmodule
